keypad_entry: RTL and testbench
===============================

KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, number of consecutive identical samples needed to accept a press or a release (legal range 2..255).
REQ-002 SHALL have port clk  input  1  the single clock; every register updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset: asynchronous assert, active-low.
REQ-004 SHALL have port key_valid  input  1  from the keypad decoder; exactly one row and one column active.
REQ-005 SHALL have port key_value  input  4  from the keypad decoder: 0-9 digits, 10 '*', 15 '#', 11-14 no key.
REQ-006 SHALL have port key_press  output  1  one-cycle pulse when a debounced press is accepted.
REQ-007 SHALL have port key_code  output  4  value of the most recently accepted key, held until the next press.
REQ-008 SHALL have port digits  output  16  entry buffer of four BCD digits, newest digit in [3:0].
REQ-009 SHALL have port digit_count  output  3  number of digits in the buffer, 0..4.
REQ-010 SHALL have port code_valid  output  1  one-cycle pulse when a complete code is committed.
REQ-011 SHALL have port code_out  output  16  last committed code, held until the next commit.
REQ-012 SHALL have port entry_err  output  1  one-cycle pulse on a digit overflow or an early '#'.

Function
REQ-013 SHALL treat a sample as "active" only when key_valid=1 and key_value is in 0-10 or 15; any other sample is "idle".
REQ-014 SHALL implement FSM states IDLE, PRESS_DB, PRESSED and REL_DB.
REQ-015 In IDLE, an active sample SHALL latch the candidate value, clear the counter and move to PRESS_DB.
REQ-016 In PRESS_DB, an idle sample or one differing from the candidate SHALL return the FSM to IDLE; otherwise the counter SHALL increment.
REQ-017 When the counter in PRESS_DB reaches DEBOUNCE_CYCLES-1, the FSM SHALL enter PRESSED and register the accept actions (key_press=1, key_code=candidate, buffer action) on that same edge.
REQ-018 As a result, key_press SHALL rise DEBOUNCE_CYCLES edges after the first edge that samples a stable active value.
REQ-019 In PRESSED, the FSM SHALL ignore any active sample, including a changed value, and SHALL move to REL_DB on an idle sample with the counter cleared.
REQ-020 In REL_DB, an active sample SHALL return the FSM to PRESSED without a new press, and DEBOUNCE_CYCLES consecutive idle samples SHALL return it to IDLE.
REQ-021 Accepting digit 0-9 with digit_count<4 SHALL shift digits left 4 bits, insert the digit at [3:0] and increment digit_count.
REQ-022 Accepting digit 0-9 with digit_count=4 SHALL leave the buffer unchanged and pulse entry_err.
REQ-023 Accepting '*' (10) SHALL clear digits and digit_count to 0, with no error even when the buffer is already empty.
REQ-024 Accepting '#' (15) with digit_count=4 SHALL load code_out from digits, pulse code_valid, and clear digits and digit_count, all on the same edge.
REQ-025 Accepting '#' with digit_count<4 SHALL pulse entry_err and leave the buffer unchanged.
REQ-026 key_press, code_valid and entry_err SHALL each be high for exactly one cycle per accepted press.
REQ-027 The counter SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits wide and SHALL saturate, never wrap.

Reset
REQ-028 rst_n=0 SHALL immediately force the FSM to IDLE, the counter to 0 and every output to 0, including digits, digit_count, key_code and code_out.
REQ-029 An assertion of rst_n in any state, including mid-debounce, SHALL discard the pending press; after release, the press is accepted only after a full new debounce period.

Configuration
REQ-030 With macro KEYPAD_ENTRY_SYNC_EN defined, key_valid and key_value SHALL pass through a two-stage synchronizer, reset to 0, before the FSM, adding exactly 2 cycles to every latency.
REQ-031 Without KEYPAD_ENTRY_SYNC_EN, the FSM SHALL sample key_valid and key_value directly, and all latencies SHALL be as stated in REQ-018.

Verification (DEBOUNCE_CYCLES=4, macro undefined unless stated)
REQ-032 Hold key_value=5 with key_valid=1 for 10 cycles, then idle for 4 -> key_press rises on the 4th edge, once; key_code=5, digits=0x0005, digit_count=1.
REQ-033 Apply key_value=3 for 2 cycles, 1 idle cycle, then key_value=3 for 2 cycles -> no key_press, buffer unchanged.
REQ-034 Press 1,2,3,4 then '#' -> code_valid pulses once, code_out=0x1234, digits=0, digit_count=0.
REQ-035 Press 1,2,3,4,9 -> entry_err pulses on the fifth press, digits stay 0x1234; then '#' with 2 digits entered -> entry_err, code_valid stays 0.
REQ-036 Hold 7 for 5 cycles, switch to 8 while still pressed, then release -> exactly one key_press, with key_code=7.
REQ-037 Pulse rst_n low for 1 cycle mid-PRESS_DB after 12 entered; repeat the test with KEYPAD_ENTRY_SYNC_EN defined -> all outputs 0 immediately after reset; with the macro defined, key_press rises on the 6th edge.

Source files
------------

// File: rtl/keypad_entry.sv
// Debounced keypad entry: accepts key presses, collects four BCD digits, commits on '#'.
// Optional input synchronizer enabled by defining KEYPAD_ENTRY_SYNC_EN.
module keypad_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_value,
    output logic        key_press,
    output logic [3:0]  key_code,
    output logic [15:0] digits,
    output logic [2:0]  digit_count,
    output logic        code_valid,
    output logic [15:0] code_out,
    output logic        entry_err
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CntMax  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 2);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StPressDb = 2'd1;
    localparam logic [1:0] StPressed = 2'd2;
    localparam logic [1:0] StRelDb   = 2'd3;

    logic       s_valid;
    logic [3:0] s_value;

`ifdef KEYPAD_ENTRY_SYNC_EN
    logic [4:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {key_valid, key_value};
            sync2_q <= sync1_q;
        end
    end

    assign s_valid = sync2_q[4];
    assign s_value = sync2_q[3:0];
`else
    assign s_valid = key_valid;
    assign s_value = key_value;
`endif

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    cand_q, cand_d;
    logic          key_press_q, key_press_d;
    logic [3:0]    key_code_q, key_code_d;
    logic [15:0]   digits_q, digits_d;
    logic [2:0]    digit_count_q, digit_count_d;
    logic          code_valid_q, code_valid_d;
    logic [15:0]   code_out_q, code_out_d;
    logic          entry_err_q, entry_err_d;
    logic          active;
    logic          accept;

    // Codes 11-14 are the decoder's "no key" encodings.
    assign active  = s_valid && ((s_value <= 4'd10) || (s_value == 4'd15));
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (active) begin
                    cand_d  = s_value;
                    cnt_d   = '0;
                    state_d = StPressDb;
                end
            end
            StPressDb: begin
                if (!active || (s_value != cand_q)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CntLast) begin
                        state_d = StPressed;
                        accept  = 1'b1;
                    end
                end
            end
            StPressed: begin
                if (!active) begin
                    cnt_d   = '0;
                    state_d = StRelDb;
                end
            end
            StRelDb: begin
                if (active) begin
                    state_d = StPressed;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CntLast) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        key_press_d   = accept;
        key_code_d    = key_code_q;
        digits_d      = digits_q;
        digit_count_d = digit_count_q;
        code_valid_d  = 1'b0;
        code_out_d    = code_out_q;
        entry_err_d   = 1'b0;
        if (accept) begin
            key_code_d = cand_q;
            if (cand_q <= 4'd9) begin
                if (digit_count_q < 3'd4) begin
                    digits_d      = {digits_q[11:0], cand_q};
                    digit_count_d = digit_count_q + 3'd1;
                end else begin
                    entry_err_d = 1'b1;
                end
            end else if (cand_q == 4'd10) begin
                digits_d      = '0;
                digit_count_d = '0;
            end else if (digit_count_q == 3'd4) begin
                code_out_d    = digits_q;
                code_valid_d  = 1'b1;
                digits_d      = '0;
                digit_count_d = '0;
            end else begin
                entry_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            cand_q        <= '0;
            key_press_q   <= 1'b0;
            key_code_q    <= '0;
            digits_q      <= '0;
            digit_count_q <= '0;
            code_valid_q  <= 1'b0;
            code_out_q    <= '0;
            entry_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            key_press_q   <= key_press_d;
            key_code_q    <= key_code_d;
            digits_q      <= digits_d;
            digit_count_q <= digit_count_d;
            code_valid_q  <= code_valid_d;
            code_out_q    <= code_out_d;
            entry_err_q   <= entry_err_d;
        end
    end

    assign key_press   = key_press_q;
    assign key_code    = key_code_q;
    assign digits      = digits_q;
    assign digit_count = digit_count_q;
    assign code_valid  = code_valid_q;
    assign code_out    = code_out_q;
    assign entry_err   = entry_err_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed self-checking bench for keypad_entry with DEBOUNCE_CYCLES=4.
// Latency expectations follow KEYPAD_ENTRY_SYNC_EN when it is defined for the build.
module tb_keypad_entry;

    localparam int D = 4;
`ifdef KEYPAD_ENTRY_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT  = D + SYNC;
    localparam int HOLD = LAT + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_value = 4'd12;
    logic        key_press;
    logic [3:0]  key_code;
    logic [15:0] digits;
    logic [2:0]  digit_count;
    logic        code_valid;
    logic [15:0] code_out;
    logic        entry_err;

    int checks = 0;
    int errors = 0;
    int kp_n, cv_n, ee_n, tick_n, first_kp;

    keypad_entry #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_value   (key_value),
        .key_press   (key_press),
        .key_code    (key_code),
        .digits      (digits),
        .digit_count (digit_count),
        .code_valid  (code_valid),
        .code_out    (code_out),
        .entry_err   (entry_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        kp_n = 0; cv_n = 0; ee_n = 0; tick_n = 0; first_kp = 0;
    endtask

    // Advance one edge and sample outputs 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
        tick_n++;
        kp_n += int'(key_press);
        cv_n += int'(code_valid);
        ee_n += int'(entry_err);
        if (key_press && first_kp == 0) first_kp = tick_n;
    endtask

    task automatic drive(input logic v, input logic [3:0] val, input int n);
        key_valid = v;
        key_value = val;
        repeat (n) tick();
    endtask

    task automatic press(input logic [3:0] val);
        drive(1'b1, val, HOLD);
        drive(1'b0, 4'd12, HOLD);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".key_press"},   32'(key_press),   32'd0);
        chk({tag, ".key_code"},    32'(key_code),    32'd0);
        chk({tag, ".digits"},      32'(digits),      32'd0);
        chk({tag, ".digit_count"}, 32'(digit_count), 32'd0);
        chk({tag, ".code_valid"},  32'(code_valid),  32'd0);
        chk({tag, ".code_out"},    32'(code_out),    32'd0);
        chk({tag, ".entry_err"},   32'(entry_err),   32'd0);
    endtask

    initial begin
        // Reset state
        #1;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single press of 5: held 10 cycles, idle 4
        clear_counts();
        drive(1'b1, 4'd5, 10);
        drive(1'b0, 4'd12, 4 + SYNC);
        chk("p5.latency", 32'(first_kp), 32'(LAT));
        chk("p5.presses", 32'(kp_n), 32'd1);
        chk("p5.key_code", 32'(key_code), 32'd5);
        chk("p5.digits", 32'(digits), 32'h0005);
        chk("p5.count", 32'(digit_count), 32'd1);

        // Bouncy 3 never reaches a full debounce
        clear_counts();
        drive(1'b1, 4'd3, 2);
        drive(1'b0, 4'd12, 1);
        drive(1'b1, 4'd3, 2);
        drive(1'b0, 4'd12, HOLD);
        chk("bounce.presses", 32'(kp_n), 32'd0);
        chk("bounce.digits", 32'(digits), 32'h0005);
        chk("bounce.count", 32'(digit_count), 32'd1);

        // '*' clears, and again on an empty buffer without error
        clear_counts();
        press(4'd10);
        chk("star.digits", 32'(digits), 32'h0);
        chk("star.count", 32'(digit_count), 32'd0);
        press(4'd10);
        chk("star2.key_code", 32'(key_code), 32'd10);
        chk("star2.err", 32'(ee_n), 32'd0);

        // 1 2 3 4 # commits
        clear_counts();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk("code.digits_full", 32'(digits), 32'h1234);
        chk("code.count_full", 32'(digit_count), 32'd4);
        press(4'd15);
        chk("code.valid_pulses", 32'(cv_n), 32'd1);
        chk("code.code_out", 32'(code_out), 32'h1234);
        chk("code.digits", 32'(digits), 32'h0);
        chk("code.count", 32'(digit_count), 32'd0);
        chk("code.err", 32'(ee_n), 32'd0);
        chk("code.presses", 32'(kp_n), 32'd5);

        // Overflow on fifth digit, then early '#'
        clear_counts();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd9);
        chk("ovf.err", 32'(ee_n), 32'd1);
        chk("ovf.digits", 32'(digits), 32'h1234);
        chk("ovf.count", 32'(digit_count), 32'd4);
        clear_counts();
        press(4'd10); press(4'd1); press(4'd2); press(4'd15);
        chk("early.err", 32'(ee_n), 32'd1);
        chk("early.valid", 32'(cv_n), 32'd0);
        chk("early.digits", 32'(digits), 32'h0012);
        chk("early.count", 32'(digit_count), 32'd2);
        chk("early.code_out", 32'(code_out), 32'h1234);

        // Value changes while pressed: only the first value counts
        clear_counts();
        drive(1'b1, 4'd7, 5);
        drive(1'b1, 4'd8, 5);
        drive(1'b0, 4'd12, HOLD);
        chk("chg.presses", 32'(kp_n), 32'd1);
        chk("chg.key_code", 32'(key_code), 32'd7);
        chk("chg.digits", 32'(digits), 32'h0127);

        // Release bounce returns to PRESSED without a second press
        clear_counts();
        drive(1'b1, 4'd6, HOLD);
        drive(1'b0, 4'd12, 2);
        drive(1'b1, 4'd6, 3);
        drive(1'b0, 4'd12, HOLD);
        chk("relb.presses", 32'(kp_n), 32'd1);
        chk("relb.digits", 32'(digits), 32'h1276);
        chk("relb.count", 32'(digit_count), 32'd4);

        // Reset mid-debounce after entering 12
        press(4'd10); press(4'd1); press(4'd2);
        chk("rst.pre_digits", 32'(digits), 32'h0012);
        clear_counts();
        drive(1'b1, 4'd5, 2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst.async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_counts();
        drive(1'b1, 4'd5, HOLD);
        drive(1'b0, 4'd12, HOLD);
        chk("rst.latency", 32'(first_kp), 32'(LAT));
        chk("rst.presses", 32'(kp_n), 32'd1);
        chk("rst.digits", 32'(digits), 32'h0005);
        chk("rst.count", 32'(digit_count), 32'd1);
        chk("rst.code_out", 32'(code_out), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
